// File: rtl/mc_main_control.sv
// rtl/mc_main_control.sv - multi-cycle MIPS main control FSM
// Optional illegal-opcode trap enabled by defining MC_ILLEGAL_TRAP_EN.
module mc_main_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PC_write,
  output logic       PC_write_cond,
  output logic       IR_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       I_or_D,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       ALU_src_A,
  output logic       zero_ext,
  output logic [1:0] ALU_src_B,
  output logic [1:0] PC_source,
  output logic [1:0] ALU_op,
  output logic       retire,
  output logic       halt
);

  typedef enum logic [3:0] {
    ST_FETCH, ST_DECODE, ST_MEM_ADDR, ST_MEM_RD, ST_MEM_WB, ST_MEM_WR,
    ST_EXEC_R, ST_R_WB, ST_EXEC_I, ST_I_WB, ST_BRANCH, ST_JUMP, ST_HALT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t     state, nxt;
  logic [5:0] op_q;

  // op_q lets later states ignore IR changes after DECODE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_FETCH;
      op_q  <= 6'b000000;
    end else begin
      state <= nxt;
      if (state == ST_DECODE) op_q <= opcode;
    end
  end

  always_comb begin
    nxt           = state;
    PC_write      = 1'b0;
    PC_write_cond = 1'b0;
    IR_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    I_or_D        = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    ALU_src_A     = 1'b0;
    zero_ext      = 1'b0;
    ALU_src_B     = 2'b00;
    PC_source     = 2'b00;
    ALU_op        = 2'b01;
    retire        = 1'b0;
    halt          = 1'b0;
    // While reset is held every enable is masked, whatever state is current.
    if (!rst_n) begin
      nxt       = ST_FETCH;
      ALU_src_B = 2'b01;
    end else begin
      case (state)
        ST_FETCH: begin
          mem_read  = 1'b1;
          ALU_src_B = 2'b01;
          IR_write  = mem_ready;
          PC_write  = mem_ready;
          if (mem_ready) nxt = ST_DECODE;
        end
        ST_DECODE: begin
          ALU_src_B = 2'b11;
          case (opcode)
            OP_LW, OP_SW:      nxt = ST_MEM_ADDR;
            OP_RTYPE:          nxt = ST_EXEC_R;
            OP_ADDIU, OP_ORI:  nxt = ST_EXEC_I;
            OP_BEQ:            nxt = ST_BRANCH;
            OP_J:              nxt = ST_JUMP;
            default: begin
`ifdef MC_ILLEGAL_TRAP_EN
              nxt = ST_HALT;
`else
              retire = 1'b1;
              nxt    = ST_FETCH;
`endif
            end
          endcase
        end
        ST_MEM_ADDR: begin
          ALU_src_A = 1'b1;
          ALU_src_B = 2'b10;
          nxt       = (op_q == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
        end
        ST_MEM_RD: begin
          mem_read = 1'b1;
          I_or_D   = 1'b1;
          if (mem_ready) nxt = ST_MEM_WB;
        end
        ST_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          retire     = 1'b1;
          nxt        = ST_FETCH;
        end
        ST_MEM_WR: begin
          mem_write = 1'b1;
          I_or_D    = 1'b1;
          retire    = mem_ready;
          if (mem_ready) nxt = ST_FETCH;
        end
        ST_EXEC_R: begin
          ALU_src_A = 1'b1;
          ALU_op    = 2'b10;
          nxt       = ST_R_WB;
        end
        ST_R_WB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
          retire    = 1'b1;
          nxt       = ST_FETCH;
        end
        ST_EXEC_I: begin
          ALU_src_A = 1'b1;
          ALU_src_B = 2'b10;
          if (op_q == OP_ORI) begin
            ALU_op   = 2'b11;
            zero_ext = 1'b1;
          end
          nxt = ST_I_WB;
        end
        ST_I_WB: begin
          reg_write = 1'b1;
          retire    = 1'b1;
          nxt       = ST_FETCH;
        end
        ST_BRANCH: begin
          ALU_src_A     = 1'b1;
          ALU_op        = 2'b00;
          PC_write_cond = 1'b1;
          PC_source     = 2'b01;
          retire        = 1'b1;
          nxt           = ST_FETCH;
        end
        ST_JUMP: begin
          PC_write  = 1'b1;
          PC_source = 2'b10;
          retire    = 1'b1;
          nxt       = ST_FETCH;
        end
        ST_HALT: begin
`ifdef MC_ILLEGAL_TRAP_EN
          halt = 1'b1;
          nxt  = ST_HALT;
`else
          nxt  = ST_FETCH;
`endif
        end
        default: nxt = ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_main_control.sv
// tb/tb_mc_main_control.sv - scoreboard bench for mc_main_control
// Illegal-opcode expectations follow MC_ILLEGAL_TRAP_EN.
module tb_mc_main_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'b000000;
  logic       mem_ready = 1'b1;
  logic       PC_write, PC_write_cond, IR_write, mem_read, mem_write, I_or_D;
  logic       reg_write, reg_dst, mem_to_reg, ALU_src_A, zero_ext, retire, halt;
  logic [1:0] ALU_src_B, PC_source, ALU_op;

  mc_main_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .PC_write(PC_write), .PC_write_cond(PC_write_cond), .IR_write(IR_write),
    .mem_read(mem_read), .mem_write(mem_write), .I_or_D(I_or_D),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .ALU_src_A(ALU_src_A), .zero_ext(zero_ext), .ALU_src_B(ALU_src_B),
    .PC_source(PC_source), .ALU_op(ALU_op), .retire(retire), .halt(halt)
  );

  always #5 clk = ~clk;

  // Bit order: PCW PCWC IRW MRD MWR IOD RW RD M2R ASA ZX ASB[2] PCS[2] AOP[2] RET HALT
  localparam logic [18:0] B_PCW  = 19'h40000;
  localparam logic [18:0] B_PCWC = 19'h20000;
  localparam logic [18:0] B_IRW  = 19'h10000;
  localparam logic [18:0] B_MRD  = 19'h08000;
  localparam logic [18:0] B_MWR  = 19'h04000;
  localparam logic [18:0] B_IOD  = 19'h02000;
  localparam logic [18:0] B_RW   = 19'h01000;
  localparam logic [18:0] B_RD   = 19'h00800;
  localparam logic [18:0] B_M2R  = 19'h00400;
  localparam logic [18:0] B_ASA  = 19'h00200;
  localparam logic [18:0] B_ZX   = 19'h00100;
  localparam logic [18:0] B_RET  = 19'h00002;
  localparam logic [18:0] B_HALT = 19'h00001;

  typedef struct {
    string       name;
    logic [18:0] vec;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic logic [18:0] base(input logic [1:0] asb, input logic [1:0] pcs,
                                       input logic [1:0] aop);
    return {11'b0, asb, pcs, aop, 2'b00};
  endfunction

  function automatic logic [18:0] e_rst();   return base(2'b01, 2'b00, 2'b01); endfunction
  function automatic logic [18:0] e_fetch(input logic mr);
    return base(2'b01, 2'b00, 2'b01) | B_MRD | (mr ? (B_PCW | B_IRW) : 19'h0);
  endfunction
  function automatic logic [18:0] e_dec(input logic ret);
    return base(2'b11, 2'b00, 2'b01) | (ret ? B_RET : 19'h0);
  endfunction
  function automatic logic [18:0] e_madr();  return base(2'b10, 2'b00, 2'b01) | B_ASA; endfunction
  function automatic logic [18:0] e_mrd();   return base(2'b00, 2'b00, 2'b01) | B_MRD | B_IOD; endfunction
  function automatic logic [18:0] e_mwb();   return base(2'b00, 2'b00, 2'b01) | B_RW | B_M2R | B_RET; endfunction
  function automatic logic [18:0] e_mwr(input logic mr);
    return base(2'b00, 2'b00, 2'b01) | B_MWR | B_IOD | (mr ? B_RET : 19'h0);
  endfunction
  function automatic logic [18:0] e_exr();   return base(2'b00, 2'b00, 2'b10) | B_ASA; endfunction
  function automatic logic [18:0] e_rwb();   return base(2'b00, 2'b00, 2'b01) | B_RW | B_RD | B_RET; endfunction
  function automatic logic [18:0] e_exi(input logic ori);
    return ori ? (base(2'b10, 2'b00, 2'b11) | B_ASA | B_ZX) : (base(2'b10, 2'b00, 2'b01) | B_ASA);
  endfunction
  function automatic logic [18:0] e_iwb();   return base(2'b00, 2'b00, 2'b01) | B_RW | B_RET; endfunction
  function automatic logic [18:0] e_br();    return base(2'b00, 2'b01, 2'b00) | B_ASA | B_PCWC | B_RET; endfunction
  function automatic logic [18:0] e_j();     return base(2'b00, 2'b10, 2'b01) | B_PCW | B_RET; endfunction
  function automatic logic [18:0] e_halt();  return base(2'b00, 2'b00, 2'b01) | B_HALT; endfunction

  task automatic step(input string nm, input logic [5:0] op, input logic mr,
                      input logic rs, input logic [18:0] ev);
    exp_t e;
    opcode    = op;
    mem_ready = mr;
    rst_n     = rs;
    e.name    = nm;
    e.vec     = ev;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: one expected entry per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [18:0] act;
      e   = exp_q.pop_front();
      act = {PC_write, PC_write_cond, IR_write, mem_read, mem_write, I_or_D,
             reg_write, reg_dst, mem_to_reg, ALU_src_A, zero_ext, ALU_src_B,
             PC_source, ALU_op, retire, halt};
      n_cmp++;
      if (act !== e.vec) begin
        n_err++;
        $display("FAIL %s: got %b want %b", e.name, act, e.vec);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    #1;
    step("reset0", 6'b000000, 1'b1, 1'b0, e_rst());
    step("reset1", 6'b000000, 1'b1, 1'b0, e_rst());
    // addu
    step("r_fetch",  6'b000000, 1'b1, 1'b1, e_fetch(1'b1));
    step("r_decode", 6'b000000, 1'b1, 1'b1, e_dec(1'b0));
    step("r_exec",   6'b000000, 1'b1, 1'b1, e_exr());
    step("r_wb",     6'b000000, 1'b1, 1'b1, e_rwb());
    // ori; opcode changes after DECODE to check it was captured
    step("ori_fetch",  6'b001101, 1'b1, 1'b1, e_fetch(1'b1));
    step("ori_decode", 6'b001101, 1'b1, 1'b1, e_dec(1'b0));
    step("ori_exec",   6'b000000, 1'b1, 1'b1, e_exi(1'b1));
    step("ori_wb",     6'b000000, 1'b1, 1'b1, e_iwb());
    // addiu
    step("addiu_fetch",  6'b001001, 1'b1, 1'b1, e_fetch(1'b1));
    step("addiu_decode", 6'b001001, 1'b1, 1'b1, e_dec(1'b0));
    step("addiu_exec",   6'b001101, 1'b1, 1'b1, e_exi(1'b0));
    step("addiu_wb",     6'b001101, 1'b1, 1'b1, e_iwb());
    // lw with three wait cycles in MEM_RD
    step("lw_fetch",  6'b100011, 1'b1, 1'b1, e_fetch(1'b1));
    step("lw_decode", 6'b100011, 1'b1, 1'b1, e_dec(1'b0));
    step("lw_addr",   6'b100011, 1'b1, 1'b1, e_madr());
    for (int i = 0; i < 3; i++)
      step("lw_rd_wait", 6'b100011, 1'b0, 1'b1, e_mrd());
    step("lw_rd_done", 6'b100011, 1'b1, 1'b1, e_mrd());
    step("lw_wb",      6'b100011, 1'b1, 1'b1, e_mwb());
    // sw with a fetch wait and a store wait
    step("sw_fetch_wait", 6'b101011, 1'b0, 1'b1, e_fetch(1'b0));
    step("sw_fetch",      6'b101011, 1'b1, 1'b1, e_fetch(1'b1));
    step("sw_decode",     6'b101011, 1'b1, 1'b1, e_dec(1'b0));
    step("sw_addr",       6'b101011, 1'b1, 1'b1, e_madr());
    step("sw_wr_wait",    6'b101011, 1'b0, 1'b1, e_mwr(1'b0));
    step("sw_wr_done",    6'b101011, 1'b1, 1'b1, e_mwr(1'b1));
    // beq and j
    step("beq_fetch",  6'b000100, 1'b1, 1'b1, e_fetch(1'b1));
    step("beq_decode", 6'b000100, 1'b1, 1'b1, e_dec(1'b0));
    step("beq_branch", 6'b000100, 1'b1, 1'b1, e_br());
    step("j_fetch",    6'b000010, 1'b1, 1'b1, e_fetch(1'b1));
    step("j_decode",   6'b000010, 1'b1, 1'b1, e_dec(1'b0));
    step("j_jump",     6'b000010, 1'b1, 1'b1, e_j());
    // reset asserted while a store is waiting
    step("swr_fetch",    6'b101011, 1'b1, 1'b1, e_fetch(1'b1));
    step("swr_decode",   6'b101011, 1'b1, 1'b1, e_dec(1'b0));
    step("swr_addr",     6'b101011, 1'b1, 1'b1, e_madr());
    step("swr_wr_wait",  6'b101011, 1'b0, 1'b1, e_mwr(1'b0));
    step("swr_reset",    6'b101011, 1'b1, 1'b0, e_rst());
    step("post_rst_wait", 6'b101011, 1'b0, 1'b1, e_fetch(1'b0));
    step("post_rst_fetch", 6'b000000, 1'b1, 1'b1, e_fetch(1'b1));
    step("post_rst_decode", 6'b000000, 1'b1, 1'b1, e_dec(1'b0));
    step("post_rst_exec", 6'b000000, 1'b1, 1'b1, e_exr());
    step("post_rst_wb",   6'b000000, 1'b1, 1'b1, e_rwb());
    // illegal opcode
    step("ill_fetch", 6'b111111, 1'b1, 1'b1, e_fetch(1'b1));
`ifdef MC_ILLEGAL_TRAP_EN
    step("ill_decode", 6'b111111, 1'b1, 1'b1, e_dec(1'b0));
    for (int i = 0; i < 10; i++)
      step("ill_halt", 6'b000000, 1'b1, 1'b1, e_halt());
    step("ill_reset", 6'b000000, 1'b1, 1'b0, e_rst());
`else
    step("ill_decode", 6'b111111, 1'b1, 1'b1, e_dec(1'b1));
`endif
    step("ill_after_fetch", 6'b000010, 1'b1, 1'b1, e_fetch(1'b1));
    step("ill_after_decode", 6'b000010, 1'b1, 1'b1, e_dec(1'b0));
    step("ill_after_jump", 6'b000010, 1'b1, 1'b1, e_j());

    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drain: got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mc_main_control.md
# mc_main_control

Main control FSM for the multi-cycle MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and write-back cycles, and drives every datapath enable and mux select. It also produces the 2-bit `ALU_op` consumed by the ALU control stage, which combines it with the instruction funct field to select the ALU function.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `opcode` in 6: IR[31:26], valid from DECODE onward.
- `mem_ready` in 1: memory handshake; the current memory access completes in a cycle where this is 1.
- `PC_write`, `PC_write_cond`, `IR_write`, `mem_read`, `mem_write`, `I_or_D`, `reg_write`, `reg_dst`, `mem_to_reg`, `ALU_src_A`, `zero_ext` out 1 each: datapath controls.
- `ALU_src_B` out 2: 00 reg B, 01 const 4, 10 ext imm, 11 sign-ext imm<<2.
- `PC_source` out 2: 00 ALU result, 01 ALUOut, 10 jump target.
- `ALU_op` out 2: to ALU control. 10 R-type (use funct), 01 add, 11 or, 00 sub.
- `retire` out 1: one-cycle pulse in the final cycle of each instruction.
- `halt` out 1: trap indicator (see Configuration).

## Operation
- States: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, R_WB, EXEC_I, I_WB, BRANCH, JUMP, HALT.
- Opcodes:
  - 000000 R-type (addu/subu/sll/or)
  - 001001 addiu
  - 001101 ori
  - 100011 lw
  - 101011 sw
  - 000100 beq
  - 000010 j
- FETCH: `mem_read`=1, `I_or_D`=0, `ALU_src_A`=0, `ALU_src_B`=01, `ALU_op`=01, `PC_source`=00. `IR_write` and `PC_write` equal `mem_ready`. Stay in FETCH while `mem_ready`=0; otherwise go to DECODE.
- DECODE: `ALU_src_A`=0, `ALU_src_B`=11, `ALU_op`=01 (branch target into ALUOut). Next state by opcode:
  - lw/sw → MEM_ADDR
  - R → EXEC_R
  - addiu/ori → EXEC_I
  - beq → BRANCH
  - j → JUMP
  - other → illegal handling
- MEM_ADDR: `ALU_src_A`=1, `ALU_src_B`=10, `ALU_op`=01. Next: MEM_RD for lw, MEM_WR for sw.
- MEM_RD: `mem_read`=1, `I_or_D`=1. Wait on `mem_ready`, then go to MEM_WB.
- MEM_WB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0, `retire`=1. Next: FETCH.
- MEM_WR: `mem_write`=1, `I_or_D`=1. Wait on `mem_ready`; `retire`=`mem_ready`. Next: FETCH.
- EXEC_R: `ALU_src_A`=1, `ALU_src_B`=00, `ALU_op`=10. Next: R_WB.
- R_WB: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0, `retire`=1. Next: FETCH.
- EXEC_I: `ALU_src_A`=1, `ALU_src_B`=10. `ALU_op`=01 and `zero_ext`=0 for addiu; `ALU_op`=11 and `zero_ext`=1 for ori. Opcode is registered at DECODE exit. Next: I_WB.
- I_WB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0, `retire`=1. Next: FETCH.
- BRANCH: `ALU_src_A`=1, `ALU_src_B`=00, `ALU_op`=00 (sub), `PC_write_cond`=1, `PC_source`=01, `retire`=1. Next: FETCH.
- JUMP: `PC_write`=1, `PC_source`=10, `retire`=1. Next: FETCH.
- Unlisted outputs are 0 in every state. `ALU_op` defaults to 01.

## Timing
- Reset: state=FETCH, registered opcode=0. All outputs at reset values: 0, except `ALU_op`=01 and `ALU_src_B`=01 as FETCH drives them. `PC_write`/`IR_write` stay 0 during reset regardless of `mem_ready`.
- Reset asserted mid-instruction: the next edge forces FETCH. No write enable is asserted in the cycle after reset is released unless FETCH sees `mem_ready`=1.
- Latency with `mem_ready` held at 1:
  - R, addiu, ori, sw: 4 cycles
  - lw: 5 cycles
  - beq, j: 3 cycles
- Each wait cycle (`mem_ready`=0 in FETCH, MEM_RD or MEM_WR) adds one cycle. Memory controls stay asserted and stable throughout the wait.
- `retire` fires exactly once per instruction.

## Configuration
- `MC_ILLEGAL_TRAP_EN` defined: an unknown opcode in DECODE goes to HALT. HALT asserts `halt`=1 with all write enables at 0, and holds until `rst_n`=0.
- `MC_ILLEGAL_TRAP_EN` undefined: an unknown opcode returns to FETCH with `retire`=1 (executed as a NOP). HALT is unreachable and `halt` is tied to 0.

## Test plan
- Reset, then addu (`opcode`=000000) with `mem_ready`=1 → states FETCH, DECODE, EXEC_R, R_WB. `ALU_op`=10 in EXEC_R; `reg_write`=`reg_dst`=1 in R_WB; `retire` pulses at cycle 4.
- ori (001101) → `ALU_op`=11 and `zero_ext`=1 in EXEC_I; `reg_write`=1, `reg_dst`=0 in I_WB.
- lw with `mem_ready` low for 3 cycles in MEM_RD → `mem_read`=`I_or_D`=1 held for 4 cycles; `mem_to_reg`=1 in MEM_WB; total 8 cycles.
- beq (000100) → `ALU_op`=00, `PC_write_cond`=1, `PC_source`=01 in cycle 3; j → `PC_write`=1, `PC_source`=10 in cycle 3.
- `rst_n`=0 during MEM_WR → next state FETCH, `mem_write`=0, no `retire`.
- Opcode 111111 → with `MC_ILLEGAL_TRAP_EN`: `halt`=1, stuck in HALT for 10 cycles until reset. Without it: back to FETCH with `retire`=1.
